// File: rtl/ita_qk_tile_sequencer_pkg.sv
// Shared types and constants for the QK tile sequencer.
// Step encoding, counter width, tile geometry and the sequencer state set.
package ita_qk_tile_sequencer_pkg;

    localparam int unsigned M    = 64;
    localparam int unsigned N    = 16;
    localparam int unsigned CntW = 16;

    typedef logic [CntW-1:0] counter_t;

    typedef enum logic [1:0] {
        Idle = 2'd0,
        QK   = 2'd1
    } step_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Beats needed to cover one MxM tile with N results per beat.
    function automatic int unsigned beats_per_tile(input int unsigned m, input int unsigned n);
        return (m * m) / n;
    endfunction

endpackage

// File: rtl/ita_qk_tile_sequencer_wrap_counter.sv
// Enable-driven counter that wraps to zero after reaching a runtime maximum.
// wrap_o flags the enabled cycle in which the wrap happens, for chaining.
module ita_wrap_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] max_i,
    output logic [W-1:0] val_o,
    output logic         wrap_o
);

    logic [W-1:0] r_val;

    assign wrap_o = en_i && (r_val == max_i);
    assign val_o  = r_val;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_val <= '0;
        end else if (en_i) begin
            r_val <= wrap_o ? '0 : r_val + W'(1);
        end
    end

endmodule

// File: rtl/ita_qk_tile_sequencer.sv
// Walks tile_y -> tile_x -> inner tile -> beat for the QK step of one head,
// emitting one beat per cycle whenever the downstream is ready.
module ita_qk_tile_sequencer #(
    parameter int unsigned M    = ita_qk_tile_sequencer_pkg::M,
    parameter int unsigned N    = ita_qk_tile_sequencer_pkg::N,
    parameter int unsigned CntW = ita_qk_tile_sequencer_pkg::CntW
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             start_i,
    input  logic                             abort_i,
    input  logic [CntW-1:0]                  tile_s_i,
    input  logic [CntW-1:0]                  tile_e_i,
    input  logic                             ready_i,
    output ita_qk_tile_sequencer_pkg::step_e step_o,
    output logic                             calc_en_o,
    output logic [CntW-1:0]                  count_o,
    output logic [CntW-1:0]                  tile_x_o,
    output logic [CntW-1:0]                  tile_y_o,
    output logic                             last_inner_tile_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             err_o
);

    import ita_qk_tile_sequencer_pkg::*;

    localparam logic [CntW-1:0] CNT_MAX = CntW'(beats_per_tile(M, N) - 1);

    seq_state_e      r_state, w_next;
    logic [CntW-1:0] r_tile_s_m1, r_tile_e_m1;
    logic            r_err;

    logic            w_run, w_cfg_zero, w_start_ok, w_calc_en, w_clr;
    logic            w_cnt_wrap, w_inner_wrap, w_x_wrap, w_y_wrap;
    logic [CntW-1:0] w_inner;

    assign w_run      = (r_state == RUN);
    assign w_cfg_zero = (tile_s_i == '0) || (tile_e_i == '0);
    assign w_start_ok = (r_state == IDLE) && start_i && !w_cfg_zero;
    assign w_calc_en  = w_run && ready_i;
    // Counters sit at zero outside RUN, so a fresh run always starts at beat 0.
    assign w_clr      = !w_run || abort_i;

    ita_wrap_counter #(.W(CntW)) u_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(w_calc_en), .clr_i(w_clr),
        .max_i(CNT_MAX), .val_o(count_o), .wrap_o(w_cnt_wrap)
    );

    ita_wrap_counter #(.W(CntW)) u_inner (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(w_cnt_wrap), .clr_i(w_clr),
        .max_i(r_tile_e_m1), .val_o(w_inner), .wrap_o(w_inner_wrap)
    );

    ita_wrap_counter #(.W(CntW)) u_x (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(w_inner_wrap), .clr_i(w_clr),
        .max_i(r_tile_s_m1), .val_o(tile_x_o), .wrap_o(w_x_wrap)
    );

    ita_wrap_counter #(.W(CntW)) u_y (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(w_x_wrap), .clr_i(w_clr),
        .max_i(r_tile_s_m1), .val_o(tile_y_o), .wrap_o(w_y_wrap)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_next = RUN;
            // Abort wins over a coinciding final beat: no DONE pulse.
            RUN:     if (abort_i) w_next = IDLE;
                     else if (w_y_wrap) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_err       <= 1'b0;
            r_tile_s_m1 <= '0;
            r_tile_e_m1 <= '0;
        end else begin
            r_state <= w_next;
            r_err   <= (r_state == IDLE) && start_i && w_cfg_zero;
            if (w_start_ok) begin
                r_tile_s_m1 <= tile_s_i - CntW'(1);
                r_tile_e_m1 <= tile_e_i - CntW'(1);
            end
        end
    end

    assign step_o            = w_run ? QK : Idle;
    assign calc_en_o         = w_calc_en;
    assign last_inner_tile_o = w_run && (w_inner == r_tile_e_m1);
    assign busy_o            = w_run;
    assign done_o            = (r_state == DONE);
    assign err_o             = r_err;

endmodule

// File: tb/tb_ita_qk_tile_sequencer.sv
// Randomized self-checking bench for ita_qk_tile_sequencer against a
// beat-index reference model (beat k -> count/inner/x/y by division).
module tb_ita_qk_tile_sequencer;
    import ita_qk_tile_sequencer_pkg::*;

    localparam int CW  = 16;
    localparam int BPT = 64 * 64 / 16;

    logic          clk = 1'b0;
    logic          rst_i, start_i, abort_i, ready_i;
    logic [CW-1:0] tile_s_i, tile_e_i;
    step_e         step_o;
    logic          calc_en_o, last_inner_tile_o, busy_o, done_o, err_o;
    logic [CW-1:0] count_o, tile_x_o, tile_y_o;

    int n_chk  = 0;
    int n_pass = 0;

    ita_qk_tile_sequencer dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .tile_s_i(tile_s_i), .tile_e_i(tile_e_i), .ready_i(ready_i),
        .step_o(step_o), .calc_en_o(calc_en_o), .count_o(count_o),
        .tile_x_o(tile_x_o), .tile_y_o(tile_y_o),
        .last_inner_tile_o(last_inner_tile_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Runs one start..finish sequence. mode 0: always ready; mode 1: ready low
    // on cycles 10-14 then ~30% random stalls. abort/rst fire on the given beat.
    task automatic drive_run(input int ts, input int te, input int mode,
                             input int abort_beat, input int rst_beat,
                             input bit poke_start);
        int  k, cyc, total, inner;
        bit  rdy, ab, rs;
        total = ts * ts * te * BPT;
        start_i = 1; tile_s_i = CW'(ts); tile_e_i = CW'(te); ready_i = 0;
        @(posedge clk); #1;
        start_i = 0;
        k = 0; cyc = 0; ab = 0; rs = 0;
        while (k < total && cyc < total * 4 + 50) begin
            if (mode == 0) rdy = 1;
            else if (cyc >= 10 && cyc <= 14) rdy = 0;
            else rdy = ($urandom_range(0, 99) >= 30);
            ready_i  = rdy;
            ab       = (k == abort_beat) && rdy;
            abort_i  = ab;
            rs       = (k == rst_beat);
            rst_i    = rs;
            start_i  = poke_start && (cyc % 37 == 5);
            tile_s_i = CW'($urandom_range(1, 3));
            tile_e_i = CW'($urandom_range(1, 3));
            #1;
            inner = (k / BPT) % te;
            n_chk++;
            if (busy_o !== 1'b1 || step_o !== QK || done_o !== 1'b0 || err_o !== 1'b0)
                $display("FAIL run_status beat=%0d busy=%b step=%0d done=%b err=%b need 1/QK/0/0",
                         k, busy_o, step_o, done_o, err_o);
            else n_pass++;
            n_chk++;
            if (calc_en_o !== rdy)
                $display("FAIL calc_en beat=%0d got=%b need=%b", k, calc_en_o, rdy);
            else n_pass++;
            n_chk++;
            if (count_o !== CW'(k % BPT) || tile_x_o !== CW'((k / (BPT * te)) % ts) ||
                tile_y_o !== CW'(k / (BPT * te * ts)) ||
                last_inner_tile_o !== (inner == te - 1))
                $display("FAIL beat_pos beat=%0d got c=%0d x=%0d y=%0d li=%b need c=%0d x=%0d y=%0d li=%b",
                         k, count_o, tile_x_o, tile_y_o, last_inner_tile_o, k % BPT,
                         (k / (BPT * te)) % ts, k / (BPT * te * ts), inner == te - 1);
            else n_pass++;
            if (rdy) k++;
            @(posedge clk); #1;
            abort_i = 0; rst_i = 0; start_i = 0;
            cyc++;
            if (ab || rs) break;
        end
        ready_i = 1;
        #1;
        if (ab || rs) begin
            n_chk++;
            if (busy_o !== 0 || done_o !== 0 || calc_en_o !== 0 || step_o !== Idle ||
                count_o !== '0 || tile_x_o !== '0 || tile_y_o !== '0 || last_inner_tile_o !== 0)
                $display("FAIL drop_to_idle busy=%b done=%b calc=%b step=%0d c=%0d x=%0d y=%0d need all 0",
                         busy_o, done_o, calc_en_o, step_o, count_o, tile_x_o, tile_y_o);
            else n_pass++;
            ready_i = 0;
            @(posedge clk); #1;
            n_chk++;
            if (done_o !== 0 || busy_o !== 0)
                $display("FAIL no_done_after_drop done=%b busy=%b need 0/0", done_o, busy_o);
            else n_pass++;
        end else if (k < total) begin
            n_chk++;
            $display("FAIL run_timeout beats=%0d need=%0d", k, total);
        end else begin
            n_chk++;
            if (done_o !== 1 || busy_o !== 0 || step_o !== Idle || calc_en_o !== 0 || count_o !== '0)
                $display("FAIL done_pulse done=%b busy=%b step=%0d calc=%b c=%0d need 1/0/Idle/0/0",
                         done_o, busy_o, step_o, calc_en_o, count_o);
            else n_pass++;
            if (mode == 0) begin
                n_chk++;
                if (cyc !== total)
                    $display("FAIL qk_cycles got=%0d need=%0d", cyc, total);
                else n_pass++;
            end
            ready_i = 0;
            @(posedge clk); #1;
            n_chk++;
            if (done_o !== 0 || busy_o !== 0)
                $display("FAIL done_one_cycle done=%b busy=%b need 0/0", done_o, busy_o);
            else n_pass++;
        end
        ready_i = 0;
    endtask

    task automatic test_reset();
        rst_i = 1; start_i = 0; abort_i = 0; ready_i = 1; tile_s_i = 0; tile_e_i = 0;
        repeat (2) @(posedge clk);
        #1; rst_i = 0;
        n_chk++;
        if (busy_o !== 0 || done_o !== 0 || err_o !== 0 || calc_en_o !== 0 || step_o !== Idle ||
            count_o !== '0 || tile_x_o !== '0 || tile_y_o !== '0 || last_inner_tile_o !== 0)
            $display("FAIL reset_state busy=%b done=%b err=%b calc=%b step=%0d c=%0d need all 0",
                     busy_o, done_o, err_o, calc_en_o, step_o, count_o);
        else n_pass++;
        ready_i = 0;
    endtask

    task automatic test_err();
        for (int i = 0; i < 2; i++) begin
            start_i = 1; tile_s_i = (i == 0) ? '0 : CW'(2); tile_e_i = (i == 0) ? CW'(1) : '0;
            @(posedge clk); #1;
            start_i = 0;
            n_chk++;
            if (err_o !== 1 || busy_o !== 0)
                $display("FAIL err_pulse case=%0d err=%b busy=%b need 1/0", i, err_o, busy_o);
            else n_pass++;
            @(posedge clk); #1;
            n_chk++;
            if (err_o !== 0 || busy_o !== 0)
                $display("FAIL err_clear case=%0d err=%b busy=%b need 0/0", i, err_o, busy_o);
            else n_pass++;
        end
        abort_i = 1; ready_i = 1;
        @(posedge clk); #1;
        abort_i = 0;
        n_chk++;
        if (busy_o !== 0 || err_o !== 0 || done_o !== 0 || calc_en_o !== 0)
            $display("FAIL abort_in_idle busy=%b err=%b done=%b calc=%b need 0", busy_o, err_o, done_o, calc_en_o);
        else n_pass++;
        ready_i = 0;
    endtask

    task automatic test_single_tile();   drive_run(1, 1, 0, -1, -1, 0); endtask
    task automatic test_multi_tile();    drive_run(2, 2, 0, -1, -1, 0); endtask
    task automatic test_backpressure();  drive_run(1, 1, 1, -1, -1, 0); endtask
    task automatic test_start_in_run();  drive_run(1, 1, 1, -1, -1, 1); endtask
    task automatic test_abort();
        drive_run(2, 1, 0, 300, -1, 0);
        drive_run(1, 1, 0, -1, -1, 0);
    endtask
    task automatic test_abort_final();   drive_run(1, 1, 0, BPT - 1, -1, 0); endtask
    task automatic test_reset_mid_run();
        drive_run(1, 1, 0, -1, 100, 0);
        drive_run(1, 2, 1, -1, -1, 0);
    endtask

    initial begin
        test_reset();
        test_err();
        test_single_tile();
        test_multi_tile();
        test_backpressure();
        test_start_in_run();
        test_abort();
        test_abort_final();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
